// File: rtl/inert_spi_resp.sv
// SPI responder standing in for the segway's inertial sensor: register access, pitch samples, data-ready INT.
// Optional build macro INERT_OVERRUN_EN adds a sticky overrun flag in STATUS bit7.
module inert_spi_resp #(
    parameter int         SAMPLE_PERIOD = 2048,
    parameter logic [7:0] WHO_AM_I_VAL  = 8'h6A
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               SS_n,
    input  logic               SCLK,
    input  logic               MOSI,
    output logic               MISO,
    output logic               INT,
    input  logic signed [15:0] ptch_smpl,
    output logic               frm_done
);

    localparam int TW = $clog2(SAMPLE_PERIOD + 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(SAMPLE_PERIOD - 1);

    localparam logic [6:0] A_INT1_CTRL = 7'h0D;
    localparam logic [6:0] A_WHO_AM_I  = 7'h0F;
    localparam logic [6:0] A_CTRL2_G   = 7'h11;
    localparam logic [6:0] A_STATUS    = 7'h1E;
    localparam logic [6:0] A_SMPL_L    = 7'h22;
    localparam logic [6:0] A_SMPL_H    = 7'h23;

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DONE} state_t;

    logic [2:0]         r_ss_sync, r_sclk_sync, r_mosi_sync;
    state_t             r_state;
    logic [4:0]         r_cnt;
    logic [15:0]        r_shft;
    logic               r_rw;
    logic [6:0]         r_addr;
    logic               r_frm_done, r_miso, r_int, r_pend;
    logic [7:0]         r_int1, r_ctrl2;
    logic [TW-1:0]      r_tmr;
    logic signed [15:0] r_smpl;

    logic w_ss_fall, w_ss_rise, w_ss_low, w_sclk_rise, w_sclk_fall, w_mosi;
    logic w_tick, w_hold, w_evt, w_int_clr, w_ovr;
    logic [7:0] w_rd_val;

    // Bit [0] is stage 1; edges compare stage 2 against stage 3.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ss_sync   <= 3'b111;
            r_sclk_sync <= 3'b111;
            r_mosi_sync <= 3'b000;
        end else begin
            r_ss_sync   <= {r_ss_sync[1:0], SS_n};
            r_sclk_sync <= {r_sclk_sync[1:0], SCLK};
            r_mosi_sync <= {r_mosi_sync[1:0], MOSI};
        end
    end

    assign w_ss_fall   = ~r_ss_sync[1] &  r_ss_sync[2];
    assign w_ss_rise   =  r_ss_sync[1] & ~r_ss_sync[2];
    assign w_ss_low    = ~r_ss_sync[1];
    assign w_sclk_rise =  r_sclk_sync[1] & ~r_sclk_sync[2];
    assign w_sclk_fall = ~r_sclk_sync[1] &  r_sclk_sync[2];
    assign w_mosi      =  r_mosi_sync[2];

    // After 8 shifts the command byte sits in r_shft[7:0].
    always_comb begin
        w_rd_val = 8'h00;
        case (r_shft[6:0])
            A_INT1_CTRL: w_rd_val = r_int1;
            A_WHO_AM_I:  w_rd_val = WHO_AM_I_VAL;
            A_CTRL2_G:   w_rd_val = r_ctrl2;
            A_STATUS:    w_rd_val = {w_ovr, 5'b00000, r_int, 1'b0};
            A_SMPL_L:    w_rd_val = r_smpl[7:0];
            A_SMPL_H:    w_rd_val = r_smpl[15:8];
            default:     w_rd_val = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 5'd0;
            r_rw       <= 1'b0;
            r_addr     <= 7'h00;
            r_frm_done <= 1'b0;
            r_miso     <= 1'b0;
            r_int1     <= 8'h00;
            r_ctrl2    <= 8'h00;
        end else begin
            r_frm_done <= 1'b0;
            if (!w_ss_low)
                r_miso <= 1'b0;
            else if (w_sclk_fall)
                r_miso <= r_shft[15];
            case (r_state)
                S_IDLE: begin
                    if (w_ss_fall) begin
                        r_cnt   <= 5'd0;
                        r_shft  <= 16'h0000;
                        r_state <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (w_ss_rise) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == 5'd8) begin
                        r_shft[15:8] <= w_rd_val;
                        r_rw         <= r_shft[7];
                        r_addr       <= r_shft[6:0];
                        r_state      <= S_DATA;
                    end else if (w_sclk_rise) begin
                        r_shft <= {r_shft[14:0], w_mosi};
                        r_cnt  <= r_cnt + 5'd1;
                    end
                end
                S_DATA: begin
                    // Frames shorter than 16 bits are dropped without side effects.
                    if (w_ss_rise) begin
                        if (r_cnt == 5'd16) begin
                            r_state    <= S_DONE;
                            r_frm_done <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (w_sclk_rise && r_cnt != 5'd16) begin
                        r_shft <= {r_shft[14:0], w_mosi};
                        r_cnt  <= r_cnt + 5'd1;
                    end
                end
                S_DONE: begin
                    if (!r_rw) begin
                        if (r_addr == A_INT1_CTRL) r_int1  <= r_shft[7:0];
                        if (r_addr == A_CTRL2_G)   r_ctrl2 <= r_shft[7:0];
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A sample landing during a sample-register read is parked until the frame is over.
    assign w_hold    = (r_state == S_DATA || r_state == S_DONE) &&
                       (r_addr == A_SMPL_L || r_addr == A_SMPL_H);
    assign w_tick    = r_int1[1] && (r_tmr == TMR_LAST);
    assign w_evt     = (w_tick || r_pend) && !w_hold;
    assign w_int_clr = (r_state == S_DONE) && r_rw && (r_addr == A_SMPL_H);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmr  <= '0;
            r_pend <= 1'b0;
            r_int  <= 1'b0;
            r_smpl <= 16'sh0000;
        end else begin
            if (!r_int1[1] || w_tick)
                r_tmr <= '0;
            else
                r_tmr <= r_tmr + TW'(1);
            if (w_evt)
                r_pend <= 1'b0;
            else if (w_tick)
                r_pend <= 1'b1;
            if (w_evt)
                r_smpl <= ptch_smpl;
            if (w_evt)
                r_int <= 1'b1;
            else if (w_int_clr)
                r_int <= 1'b0;
        end
    end

`ifdef INERT_OVERRUN_EN
    logic r_ovr;

    always_ff @(posedge clk) begin
        if (rst)
            r_ovr <= 1'b0;
        else if (w_evt && r_int)
            r_ovr <= 1'b1;
        else if (r_state == S_DONE && r_rw && r_addr == A_STATUS)
            r_ovr <= 1'b0;
    end

    assign w_ovr = r_ovr;
`else
    assign w_ovr = 1'b0;
`endif

    assign MISO     = r_miso;
    assign INT      = r_int;
    assign frm_done = r_frm_done;

endmodule

// File: doc/inert_spi_resp.md
Name: inert_spi_resp

Overview:
- Synthesizable SPI responder that models the inertial sensor at the far end of the segway's inertial SPI link.
- Answers 16-bit SPI frames from the inertial interface master: register writes, register reads, and pitch-rate sample reads.
- Generates a periodic data-ready INT.
- Used in full-chip simulation and in FPGA bring-up in place of the physical sensor.

Parameters:
- SAMPLE_PERIOD, 2048: clk cycles between new pitch samples while data-ready is enabled.
- WHO_AM_I_VAL, 8'h6A: read-only identification value at address 0x0F.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- SS_n  in  1  SPI slave select, active low
- SCLK  in  1  SPI clock from master, idles high
- MOSI  in  1  SPI data from master
- MISO  out  1  SPI data to master
- INT  out  1  data-ready interrupt, active high
- ptch_smpl  in  16  signed pitch rate, captured at each sample event
- frm_done  out  1  one-cycle pulse when a complete 16-bit frame ends

Behaviour:
- Reset and clocking:
  - Reset is synchronous, active-high; one clock.
  - SS_n, SCLK and MOSI each pass through 3-flop synchronizers. Edges are detected between stages 2 and 3.
  - Synchronizer reset values: SS_n and SCLK reset to 1, MOSI resets to 0.
- Frame format:
  - MSB first, 16 bits.
  - bit15 = R/W (1 = read), bits14:8 = address, bits7:0 = write data (ignored on reads).
- SPI timing:
  - MOSI is sampled on SCLK rising edges.
  - MISO changes on SCLK falling edges.
  - MISO = shft[15] while SS_n is low; MISO = 0 while SS_n is high.
- FSM states:
  - IDLE: waits for SS_n falling edge. Then bit counter := 0, shft := 0 → CMD.
  - CMD: shifts in on each SCLK rising edge. After the 8th rising edge, the addressed register value is loaded into shft[15:8] on the next clk → DATA.
  - DATA: shifts until 16 rising edges are counted. On SS_n rising edge → DONE.
  - In any state, SS_n rising with bit count < 16 → IDLE. The frame is discarded: no write, no INT clear, no frm_done.
  - Rising edges beyond 16 are ignored; the counter saturates at 16.
  - DONE (one cycle):
    - Pulse frm_done.
    - If write, commit data to a writable register.
    - If read of 0x23, clear INT.
    - → IDLE.
- Register map (unmapped reads return 8'h00; writes to read-only or unmapped addresses are ignored):
  - 0x0D INT1_CTRL: R/W, reset 8'h00. Bit1 = data-ready enable.
  - 0x0F WHO_AM_I: read-only, WHO_AM_I_VAL.
  - 0x11 CTRL2_G: R/W, reset 8'h00. Stored only.
  - 0x1E STATUS: read-only.
    - bit1 = INT.
    - bit7 = overrun (optional feature; otherwise 0).
  - 0x22 / 0x23: pitch sample low / high byte (read-only).
- Sample timer:
  - Counts only while INT1_CTRL[1] = 1; cleared to 0 when the enable is 0.
  - At count SAMPLE_PERIOD-1: wrap to 0, capture ptch_smpl into the sample register, set INT the next cycle.
  - Simultaneous sample event and 0x23-read DONE: the set wins (INT stays 1, new sample captured).
  - Capture is held off while the FSM is in DATA with address 0x22 or 0x23. The event is deferred to the cycle after DONE/abort so a read pair is never torn; the timer keeps running.
- Reset values: MISO = 0, INT = 0, frm_done = 0, all registers as listed above, sample register = 16'h0000, FSM in IDLE.

Optional Feature:
- Macro: INERT_OVERRUN_EN.
- Defined:
  - STATUS bit7 is a sticky overrun flag, set when a sample event occurs while INT is already 1.
  - Cleared in DONE of a read of 0x1E.
- Undefined:
  - STATUS bit7 reads 0; no overrun logic is present.

Test Plan:
- Read WHO_AM_I: frame 16'h8F00 after reset → MISO returns 8'h6A in bits7:0, first byte 8'h00; frm_done pulses once.
- Enable data-ready with ptch_smpl = 16'h1234:
  - Write frame 16'h0D02 → INT rises SAMPLE_PERIOD clks after the write commit (±1).
  - Read 16'hA200 → 8'h34; read 16'hA300 → 8'h12.
  - INT clears one cycle after the 0x23 frame's SS_n rise.
- Aborted frame: drop SS_n, give 10 SCLK edges of 16'h0DFF, raise SS_n → INT1_CTRL unchanged at 8'h02, no frm_done.
- Read-only protect: write 16'h0F55, then read 0x0F → 8'h6A.
- Overrun (INERT_OVERRUN_EN defined):
  - Leave INT unserviced for 2 periods → read 16'h9E00 returns 8'h82.
  - An immediate re-read returns 8'h02.
  - With the macro undefined, the first read returns 8'h02.
- Reset mid-frame: assert rst during DATA → MISO = 0, INT = 0, FSM in IDLE; the next full 16'h8F00 frame reads 8'h6A.
